// File: rtl/ps2_kbd_rx.sv
// ps2_kbd_rx: PS/2 keyboard receiver. Synchronizes and filters the PS/2 lines,
//   deframes 11-bit frames (start, 8 data LSB first, odd parity, stop) into bytes,
//   and strips scan-code-set-2 prefixes (E0 ext, F0 break, E1 pause) into key events.
// Latency: line fall to bit event 2+FILTER cycles; rx_strobe/rx_error the cycle after
//   the stop-bit event; key_strobe one cycle after rx_strobe. No backpressure.
// Ports: clk/reset (sync, active-high); ps2_clk/ps2_data async inputs;
//   rx_byte/rx_strobe/rx_error byte interface; key_code/key_ext/key_released/key_strobe.
module ps2_kbd_rx #(
  parameter int FILTER  = 4,
  parameter int TO_BITS = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [7:0] rx_byte,
  output logic       rx_strobe,
  output logic       rx_error,
  output logic [7:0] key_code,
  output logic       key_ext,
  output logic       key_released,
  output logic       key_strobe
);

  localparam int FW = $clog2(FILTER + 1);

  typedef enum logic [1:0] {S_IDLE, S_DATA, S_PARITY, S_STOP} state_t;

  state_t             state_q, state_d;
  logic               clk_s1_q, clk_s1_d, clk_s2_q, clk_s2_d;
  logic               dat_s1_q, dat_s1_d, dat_s2_q, dat_s2_d;
  logic               filt_q, filt_d;
  logic [FW-1:0]      filt_cnt_q, filt_cnt_d;
  logic [TO_BITS-1:0] to_cnt_q, to_cnt_d;
  logic [2:0]         bit_cnt_q, bit_cnt_d;
  logic [7:0]         shreg_q, shreg_d;
  logic               par_acc_q, par_acc_d;
  logic               par_ok_q, par_ok_d;
  logic [7:0]         rx_byte_q, rx_byte_d;
  logic               rx_strobe_q, rx_strobe_d;
  logic               rx_error_q, rx_error_d;
  logic               ext_q, ext_d, rel_q, rel_d;
  logic [2:0]         skip_q, skip_d;
  logic [7:0]         key_code_q, key_code_d;
  logic               key_ext_q, key_ext_d, key_rel_q, key_rel_d;
  logic               key_strobe_q, key_strobe_d;
  logic               bit_evt, to_full, is_resp;

  always_comb begin
    state_d      = state_q;
    clk_s1_d     = ps2_clk;
    clk_s2_d     = clk_s1_q;
    dat_s1_d     = ps2_data;
    dat_s2_d     = dat_s1_q;
    filt_d       = filt_q;
    filt_cnt_d   = filt_cnt_q;
    to_cnt_d     = to_cnt_q;
    bit_cnt_d    = bit_cnt_q;
    shreg_d      = shreg_q;
    par_acc_d    = par_acc_q;
    par_ok_d     = par_ok_q;
    rx_byte_d    = rx_byte_q;
    rx_strobe_d  = 1'b0;
    rx_error_d   = 1'b0;
    ext_d        = ext_q;
    rel_d        = rel_q;
    skip_d       = skip_q;
    key_code_d   = key_code_q;
    key_ext_d    = key_ext_q;
    key_rel_d    = key_rel_q;
    key_strobe_d = 1'b0;
    bit_evt      = 1'b0;
    is_resp      = 1'b0;

    // Stability filter: a differing sample run must last FILTER cycles.
    if (clk_s2_q == filt_q) begin
      filt_cnt_d = '0;
    end else if (filt_cnt_q == FW'(FILTER - 1)) begin
      filt_d     = clk_s2_q;
      filt_cnt_d = '0;
      bit_evt    = filt_q;  // high-to-low flip of the filtered clock
    end else begin
      filt_cnt_d = filt_cnt_q + 1'b1;
    end

    // Saturating inter-edge counter; only acted on outside IDLE.
    to_full = &to_cnt_q;
    if (bit_evt) begin
      to_cnt_d = '0;
    end else if (!to_full) begin
      to_cnt_d = to_cnt_q + 1'b1;
    end

    case (state_q)
      S_IDLE: begin
        if (bit_evt && !dat_s2_q) begin
          state_d   = S_DATA;
          bit_cnt_d = '0;
          par_acc_d = 1'b1;
        end
      end
      S_DATA: begin
        if (bit_evt) begin
          shreg_d   = {dat_s2_q, shreg_q[7:1]};
          par_acc_d = par_acc_q ^ dat_s2_q;
          bit_cnt_d = bit_cnt_q + 1'b1;
          if (bit_cnt_q == 3'd7) state_d = S_PARITY;
        end
      end
      S_PARITY: begin
        if (bit_evt) begin
          par_ok_d = (par_acc_q == dat_s2_q);
          state_d  = S_STOP;
        end
      end
      default: begin
        if (bit_evt) begin
          if (dat_s2_q && par_ok_q) begin
            rx_byte_d   = shreg_q;
            rx_strobe_d = 1'b1;
          end else begin
            rx_error_d = 1'b1;
          end
          state_d = S_IDLE;
        end
      end
    endcase

    // A bit event in the same cycle wins over the timeout.
    if (state_q != S_IDLE && !bit_evt && to_full) begin
      rx_error_d = 1'b1;
      state_d    = S_IDLE;
    end

    case (rx_byte_q)
      8'h00, 8'hAA, 8'hEE, 8'hFA, 8'hFC, 8'hFD, 8'hFE, 8'hFF: is_resp = 1'b1;
      default: is_resp = 1'b0;
    endcase

    if (rx_error_q) begin
      ext_d  = 1'b0;
      rel_d  = 1'b0;
      skip_d = '0;
    end else if (rx_strobe_q) begin
      if (skip_q != 3'd0) begin
        skip_d = skip_q - 1'b1;
      end else if (rx_byte_q == 8'hE1) begin
        skip_d = 3'd7;  // rest of the 8-byte Pause make sequence
        ext_d  = 1'b0;
        rel_d  = 1'b0;
      end else if (rx_byte_q == 8'hE0) begin
        ext_d = 1'b1;
      end else if (rx_byte_q == 8'hF0) begin
        rel_d = 1'b1;
      end else if (!ext_q && !rel_q && is_resp) begin
        // keyboard command response, not a key
      end else begin
        key_code_d   = rx_byte_q;
        key_ext_d    = ext_q;
        key_rel_d    = rel_q;
        key_strobe_d = 1'b1;
        ext_d        = 1'b0;
        rel_d        = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_IDLE;
      clk_s1_q     <= 1'b1;
      clk_s2_q     <= 1'b1;
      dat_s1_q     <= 1'b1;
      dat_s2_q     <= 1'b1;
      filt_q       <= 1'b1;
      filt_cnt_q   <= '0;
      to_cnt_q     <= '0;
      bit_cnt_q    <= '0;
      shreg_q      <= '0;
      par_acc_q    <= 1'b0;
      par_ok_q     <= 1'b0;
      rx_byte_q    <= '0;
      rx_strobe_q  <= 1'b0;
      rx_error_q   <= 1'b0;
      ext_q        <= 1'b0;
      rel_q        <= 1'b0;
      skip_q       <= '0;
      key_code_q   <= '0;
      key_ext_q    <= 1'b0;
      key_rel_q    <= 1'b0;
      key_strobe_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      clk_s1_q     <= clk_s1_d;
      clk_s2_q     <= clk_s2_d;
      dat_s1_q     <= dat_s1_d;
      dat_s2_q     <= dat_s2_d;
      filt_q       <= filt_d;
      filt_cnt_q   <= filt_cnt_d;
      to_cnt_q     <= to_cnt_d;
      bit_cnt_q    <= bit_cnt_d;
      shreg_q      <= shreg_d;
      par_acc_q    <= par_acc_d;
      par_ok_q     <= par_ok_d;
      rx_byte_q    <= rx_byte_d;
      rx_strobe_q  <= rx_strobe_d;
      rx_error_q   <= rx_error_d;
      ext_q        <= ext_d;
      rel_q        <= rel_d;
      skip_q       <= skip_d;
      key_code_q   <= key_code_d;
      key_ext_q    <= key_ext_d;
      key_rel_q    <= key_rel_d;
      key_strobe_q <= key_strobe_d;
    end
  end

  assign rx_byte      = rx_byte_q;
  assign rx_strobe    = rx_strobe_q;
  assign rx_error     = rx_error_q;
  assign key_code     = key_code_q;
  assign key_ext      = key_ext_q;
  assign key_released = key_rel_q;
  assign key_strobe   = key_strobe_q;

endmodule

// File: tb/tb_ps2_kbd_rx.sv
module tb_ps2_kbd_rx;

  localparam int FILTER  = 4;
  localparam int TO_BITS = 12;
  localparam int H       = 10;  // PS/2 half period in core cycles

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       ps2_clk = 1'b1;
  logic       ps2_data = 1'b1;
  logic [7:0] rx_byte, key_code;
  logic       rx_strobe, rx_error, key_ext, key_released, key_strobe;

  ps2_kbd_rx #(.FILTER(FILTER), .TO_BITS(TO_BITS)) dut (
    .clk(clk), .reset(reset), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
    .rx_byte(rx_byte), .rx_strobe(rx_strobe), .rx_error(rx_error),
    .key_code(key_code), .key_ext(key_ext), .key_released(key_released),
    .key_strobe(key_strobe)
  );

  always #5 clk = ~clk;

  typedef struct { bit err; logic [7:0] b; } rx_exp_t;
  typedef struct { logic [7:0] code; bit ext; bit rel; } key_exp_t;

  rx_exp_t  rx_q[$];
  key_exp_t key_q[$];
  int checks = 0;
  int errors = 0;

  // Reference model state
  logic [7:0] m_last = 8'h00;
  bit m_ext = 0, m_rel = 0;
  int m_skip = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit is_response(input logic [7:0] b);
    logic [7:0] resp [8] = '{8'h00, 8'hAA, 8'hEE, 8'hFA, 8'hFC, 8'hFD, 8'hFE, 8'hFF};
    foreach (resp[i]) if (resp[i] == b) return 1;
    return 0;
  endfunction

  task automatic model_good(input logic [7:0] b);
    rx_exp_t e;
    key_exp_t k;
    e.err = 0; e.b = b; rx_q.push_back(e); m_last = b;
    if (m_skip > 0) m_skip--;
    else if (b == 8'hE1) begin m_skip = 7; m_ext = 0; m_rel = 0; end
    else if (b == 8'hE0) m_ext = 1;
    else if (b == 8'hF0) m_rel = 1;
    else if (!m_ext && !m_rel && is_response(b)) begin end
    else begin
      k.code = b; k.ext = m_ext; k.rel = m_rel; key_q.push_back(k);
      m_ext = 0; m_rel = 0;
    end
  endtask

  task automatic model_err();
    rx_exp_t e;
    e.err = 1; e.b = m_last; rx_q.push_back(e);
    m_ext = 0; m_rel = 0; m_skip = 0;
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic ps2_bit(input bit v, input bit glitch);
    @(negedge clk);
    ps2_data = v;
    if (glitch) begin
      cyc(3); ps2_clk = 1'b0; cyc(2); ps2_clk = 1'b1; cyc(H - 5);
    end else cyc(H);
    ps2_clk = 1'b0;
    cyc(H);
    ps2_clk = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] b, input bit bad_par, input bit bad_stop, input bit glitch);
    logic par;
    if (bad_par || bad_stop) model_err(); else model_good(b);
    par = ~(^b) ^ bad_par;
    ps2_bit(1'b0, glitch);
    for (int i = 0; i < 8; i++) ps2_bit(b[i], glitch);
    ps2_bit(par, glitch);
    ps2_bit(~bad_stop, glitch);
    @(negedge clk); ps2_data = 1'b1;
    cyc(H);
  endtask

  task automatic send_partial(input int nbits, input bit expect_err);
    if (expect_err) model_err();
    ps2_bit(1'b0, 1'b0);
    for (int i = 0; i < nbits; i++) ps2_bit(1'($urandom_range(0, 1)), 1'b0);
    @(negedge clk); ps2_data = 1'b1;
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_rx_byte"}, 32'(rx_byte), 32'h0);
    chk({tag, "_strobes"}, 32'({rx_strobe, rx_error, key_strobe}), 32'h0);
    chk({tag, "_key"}, 32'({key_code, key_ext, key_released}), 32'h0);
  endtask

  // Monitor: pops the scoreboards whenever the DUT presents an event.
  bit prev_rx_strobe = 0;
  always @(negedge clk) begin
    if (reset) begin
      prev_rx_strobe = 0;
    end else begin
      if (rx_strobe || rx_error) begin
        if (rx_q.size() == 0) begin
          chk("rx_unexpected", 32'({rx_error, rx_byte}), 32'h1ff);
        end else begin
          rx_exp_t e;
          e = rx_q.pop_front();
          chk("rx_event", 32'({rx_strobe, rx_error, rx_byte}), 32'({~e.err, e.err, e.b}));
        end
      end
      if (key_strobe) begin
        chk("key_latency", 32'(prev_rx_strobe), 32'h1);
        if (key_q.size() == 0) begin
          chk("key_unexpected", 32'({key_ext, key_released, key_code}), 32'h3ff);
        end else begin
          key_exp_t k;
          k = key_q.pop_front();
          chk("key_event", 32'({key_ext, key_released, key_code}), 32'({k.ext, k.rel, k.code}));
        end
      end
      prev_rx_strobe = rx_strobe;
    end
  end

  logic [7:0] pause_seq [8] = '{8'hE1, 8'h14, 8'h77, 8'hE1, 8'hF0, 8'h14, 8'hF0, 8'h77};
  logic [7:0] resp_tab  [8] = '{8'h00, 8'hAA, 8'hEE, 8'hFA, 8'hFC, 8'hFD, 8'hFE, 8'hFF};

  initial begin
    int r;
    logic [7:0] b;
    cyc(5);
    reset = 1'b0;
    cyc(1);
    check_reset_outputs("reset");

    // Partial frame cut off by reset: discarded with no error.
    send_partial(3, 1'b0);
    cyc(2); reset = 1'b1; cyc(3); reset = 1'b0; cyc(1);
    check_reset_outputs("midframe_reset");

    send_frame(8'h1C, 0, 0, 0);
    send_frame(8'hF0, 0, 0, 0); send_frame(8'h1C, 0, 0, 0);
    send_frame(8'hE0, 0, 0, 0); send_frame(8'hF0, 0, 0, 0); send_frame(8'h74, 0, 0, 0);
    send_frame(8'h1C, 1, 0, 0); send_frame(8'h29, 0, 0, 0);
    send_frame(8'hE0, 0, 1, 0); send_frame(8'h6B, 0, 0, 0);

    // Abort mid-frame and let the timeout expire; a pending prefix must be dropped.
    send_frame(8'hE0, 0, 0, 0);
    send_partial(4, 1'b1);
    cyc((1 << TO_BITS) + 50);
    send_frame(8'h5A, 0, 0, 0);

    foreach (pause_seq[i]) send_frame(pause_seq[i], 0, 0, 0);
    send_frame(8'h1C, 0, 0, 0);
    send_frame(8'hFA, 0, 0, 0);

    // Glitches in idle and between bits.
    @(negedge clk); ps2_clk = 1'b0; cyc(2); ps2_clk = 1'b1; cyc(H);
    send_frame(8'h1C, 0, 0, 1);

    for (int n = 0; n < 60; n++) begin
      r = $urandom_range(0, 19);
      if (r < 3)       b = 8'hE0;
      else if (r < 6)  b = 8'hF0;
      else if (r == 6) b = 8'hE1;
      else if (r < 9)  b = resp_tab[$urandom_range(0, 7)];
      else             b = 8'($urandom_range(1, 8'h83));
      r = $urandom_range(0, 19);
      send_frame(b, r == 0, r == 1, r == 2);
    end

    for (int t = 0; t < 2000 && (rx_q.size() != 0 || key_q.size() != 0); t++) cyc(1);
    chk("rx_queue_drained", 32'(rx_q.size()), 32'h0);
    chk("key_queue_drained", 32'(key_q.size()), 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
